seg7_scan_encoder: RTL and testbench

Reverse path of the seven-segment decode chain: watches a multiplexed seven-segment display bus (segment lines plus one-hot digit select), waits for each digit's pattern to be stable, and encodes it back to BCD. Once every digit position has been captured, it presents a full frame (packed BCD plus per-digit blank/error flags) on a valid/ready output. Used for display loopback checking and for reading scanned segment buses back into logic.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_pattern_enc.sv | 34 +++
 rtl/seg7_scan_encoder.sv | 122 ++++++++++++
 tb/tb_seg7_scan_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan encoder.
// The segment patterns are active-high {a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_NONE = 4'hF;

    typedef enum logic {COLLECT, PRESENT} state_t;

    typedef struct packed {
        logic [3:0] bcd;
        logic       blank;
        logic       err;
    } seg_dec_t;

    localparam seg_dec_t DEC_BLANK = '{bcd: BCD_NONE, blank: 1'b1, err: 1'b0};

endpackage

// File: rtl/seg7_pattern_enc.sv
// Combinational map from an active-high segment pattern to BCD.
// Anything that is neither a digit nor all-off is flagged as an error.
module seg7_pattern_enc
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output seg_dec_t   dec
);

    logic [3:0] bcd;
    logic       blank;

    always_comb begin
        bcd   = BCD_NONE;
        blank = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   ;
        endcase
    end

    assign dec = '{bcd: bcd, blank: blank, err: (bcd == BCD_NONE) && !blank};

endmodule

// File: rtl/seg7_scan_encoder.sv
// Watches a multiplexed seven-segment bus, captures each digit once its
// pattern is stable and presents complete frames on a valid/ready port.
module seg7_scan_encoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   dig_sel_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_blank,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    frame_drop
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CAP_AT  = CW'(STABLE_CYCLES - 1);

    logic [6:0]            seg_pol;
    seg_dec_t              dec;
    logic [6:0]            prev_seg;
    logic [NUM_DIGITS-1:0] prev_sel;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  onehot, match, capture, full;
    logic [NUM_DIGITS-1:0] cap_mask, seen, seen_nxt;
    state_t                state;

    seg_dec_t [NUM_DIGITS-1:0] slot, slot_nxt;
    logic [4*NUM_DIGITS-1:0]   frm_bcd;
    logic [NUM_DIGITS-1:0]     frm_blank, frm_err;

    assign seg_pol = SEG_ACTIVE_LOW ? ~seg_i : seg_i;

    seg7_pattern_enc u_enc (
        .seg (seg_pol),
        .dec (dec)
    );

    // Counter holds (identical cycles - 1) and saturates one past the capture
    // point, so a long dwell captures exactly once.
    assign onehot   = $onehot(dig_sel_i);
    assign match    = onehot && (seg_i == prev_seg) && (dig_sel_i == prev_sel);
    assign cnt_nxt  = match ? ((cnt == CNT_MAX) ? cnt : cnt + 1'b1) : '0;
    assign capture  = onehot && (cnt_nxt == CAP_AT);
    assign cap_mask = capture ? dig_sel_i : '0;
    assign seen_nxt = seen | cap_mask;
    assign full     = &seen_nxt;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
        assign slot_nxt[g]       = cap_mask[g] ? dec : slot[g];
        assign frm_bcd[4*g +: 4] = slot_nxt[g].bcd;
        assign frm_blank[g]      = slot_nxt[g].blank;
        assign frm_err[g]        = slot_nxt[g].err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_seg <= '0;
            prev_sel <= '0;
            cnt      <= '0;
            slot     <= {NUM_DIGITS{DEC_BLANK}};
        end else begin
            prev_seg <= seg_i;
            prev_sel <= dig_sel_i;
            cnt      <= cnt_nxt;
            slot     <= slot_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            seen       <= '0;
            out_valid  <= 1'b0;
            out_bcd    <= {NUM_DIGITS{BCD_NONE}};
            out_blank  <= '1;
            out_err    <= '0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= 1'b0;
            seen       <= seen_nxt;
            case (state)
                COLLECT: begin
                    if (full) begin
                        state     <= PRESENT;
                        seen      <= '0;
                        out_valid <= 1'b1;
                        out_bcd   <= frm_bcd;
                        out_blank <= frm_blank;
                        out_err   <= frm_err;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (full) begin
                            seen      <= '0;
                            out_bcd   <= frm_bcd;
                            out_blank <= frm_blank;
                            out_err   <= frm_err;
                        end else begin
                            state     <= COLLECT;
                            out_valid <= 1'b0;
                        end
                    end else if (full) begin
                        // Consumer still holds the old frame: discard the new one.
                        frame_drop <= 1'b1;
                        seen       <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// Randomized and directed bench for seg7_scan_encoder against a frame-level model.
module tb_seg7_scan_encoder;

    localparam int ND = 4;
    localparam int SC = 3;

    localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                        7'b1111111, 7'b1111011};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg = '0;
    logic [6:0]    seg_n;
    logic [ND-1:0] dsel = '0;
    logic          rdy = 1'b0;

    logic          v0, d0, v1, d1;
    logic [15:0]   b0, b1;
    logic [ND-1:0] bl0, er0, bl1, er1;

    assign seg_n = ~seg;

    seg7_scan_encoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .seg_i(seg), .dig_sel_i(dsel),
        .out_valid(v0), .out_ready(rdy), .out_bcd(b0), .out_blank(bl0),
        .out_err(er0), .frame_drop(d0));

    seg7_scan_encoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .seg_i(seg_n), .dig_sel_i(dsel),
        .out_valid(v1), .out_ready(rdy), .out_bcd(b1), .out_blank(bl1),
        .out_err(er1), .frame_drop(d1));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: run length of the current (seg, sel) pair and a frame of digits.
    int            run = 0;
    bit            lvalid = 0;
    logic [6:0]    lseg = '0;
    logic [ND-1:0] lsel = '0;
    int            s_bcd [ND];
    bit            s_bl  [ND];
    bit            s_er  [ND];
    bit [ND-1:0]   m_seen = '0;
    bit            m_valid = 0, m_drop = 0;
    logic [15:0]   m_bcd = 16'hFFFF;
    logic [ND-1:0] m_blank = '1, m_err = '0;
    int            dig;
    bit            cap;

    function automatic logic [5:0] decode(input logic [6:0] p);
        if (p == 7'd0) return {4'hF, 1'b1, 1'b0};
        for (int k = 0; k < 10; k++)
            if (PAT[k] == p) return {4'(k), 1'b0, 1'b0};
        return {4'hF, 1'b0, 1'b1};
    endfunction

    task automatic model_reset();
        run = 0; lvalid = 0; m_seen = '0; m_valid = 0; m_drop = 0;
        m_bcd = 16'hFFFF; m_blank = '1; m_err = '0;
        for (int i = 0; i < ND; i++) begin s_bcd[i] = 15; s_bl[i] = 1; s_er[i] = 0; end
    endtask

    task automatic model_load();
        for (int i = 0; i < ND; i++) begin
            m_bcd[4*i +: 4] = 4'(s_bcd[i]);
            m_blank[i] = s_bl[i];
            m_err[i] = s_er[i];
        end
        m_seen = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            logic [5:0] d;
            run = (lvalid && seg == lseg && dsel == lsel) ? run + 1 : 1;
            lvalid = 1; lseg = seg; lsel = dsel;
            cap = ($countones(dsel) == 1) && (run == SC);
            m_drop = 0;
            if (cap) begin
                dig = $clog2(dsel);
                d = decode(seg);
                s_bcd[dig] = int'(d[5:2]); s_bl[dig] = d[1]; s_er[dig] = d[0];
                m_seen[dig] = 1'b1;
            end
            if (&m_seen) begin
                if (!m_valid || rdy) begin model_load(); m_valid = 1; end
                else begin m_drop = 1; m_seen = '0; end
            end else if (m_valid && rdy) m_valid = 0;
        end
    end

    int          vcnt = 0, dcnt = 0;
    logic [15:0] last0 = '0, last1 = '0;
    logic [3:0]  lastbl = '0, lasterr = '0;

    task automatic compare();
        chk("valid0", 32'(v0), 32'(m_valid));
        chk("bcd0",   32'(b0), 32'(m_bcd));
        chk("blank0", 32'(bl0), 32'(m_blank));
        chk("err0",   32'(er0), 32'(m_err));
        chk("drop0",  32'(d0), 32'(m_drop));
        chk("valid1", 32'(v1), 32'(m_valid));
        chk("bcd1",   32'(b1), 32'(m_bcd));
        chk("blank1", 32'(bl1), 32'(m_blank));
        chk("err1",   32'(er1), 32'(m_err));
        chk("drop1",  32'(d1), 32'(m_drop));
        if (v0) begin vcnt++; last0 = b0; lastbl = bl0; lasterr = er0; end
        if (v1) last1 = b1;
        if (d0) dcnt++;
    endtask

    task automatic cyc(input logic [6:0] s, input logic [ND-1:0] sel, input logic r);
        seg = s; dsel = sel; rdy = r;
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    // rmode: 0 ready low, 1 ready high, 2 ready only on the last digit's capture cycle
    task automatic scan(input logic [3:0][6:0] p, input int dwell, input int rmode);
        for (int i = 0; i < ND; i++)
            for (int k = 1; k <= dwell; k++)
                cyc(p[i], ND'(1) << i, (rmode == 1) || (rmode == 2 && i == ND-1 && k == SC));
    endtask

    int vb;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare();
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_bcd",   32'(b0), 32'hFFFF);
        chk("rst_blank", 32'(bl0), 32'hF);
        rst_n = 1'b1;

        // 1: digits 1,2,3,4
        vb = vcnt;
        scan({PAT[4], PAT[3], PAT[2], PAT[1]}, 4, 1);
        chk("t1_pulses", 32'(vcnt - vb), 32'd1);
        chk("t1_bcd", 32'(last0), 32'h4321);
        chk("t1_flags", 32'({lastbl, lasterr}), 32'h00);

        // 2: blank and unrecognised digits
        scan({PAT[4], 7'b0000000, 7'b1000001, PAT[1]}, 4, 1);
        chk("t2_bcd", 32'(last0), 32'h4FF1);
        chk("t2_blank", 32'(lastbl), 32'b0100);
        chk("t2_err", 32'(lasterr), 32'b0010);

        // 3: short dwell and multi-hot select never capture
        vb = vcnt;
        scan({PAT[7], PAT[7], PAT[7], PAT[7]}, SC - 1, 1);
        for (int k = 0; k < 10; k++) cyc(PAT[8], 4'b0011, 1'b1);
        for (int k = 0; k < 6; k++) cyc(PAT[8], 4'b0000, 1'b1);
        chk("t3_pulses", 32'(vcnt - vb), 32'd0);

        // 4: held frame, dropped frame, then replace on the handshake edge
        vb = dcnt;
        scan({PAT[8], PAT[7], PAT[6], PAT[5]}, 4, 0);
        scan({PAT[1], PAT[1], PAT[1], PAT[1]}, 4, 0);
        chk("t4_drops", 32'(dcnt - vb), 32'd1);
        chk("t4_held", 32'(b0), 32'h8765);
        scan({PAT[0], PAT[9], PAT[3], PAT[2]}, 4, 2);
        chk("t4_valid", 32'(v0), 32'd1);
        chk("t4_new", 32'(b0), 32'h0932);
        cyc(PAT[2], 4'b0000, 1'b1);
        chk("t4_drained", 32'(v0), 32'd0);

        // 5: asynchronous reset while presenting
        scan({PAT[5], PAT[5], PAT[5], PAT[5]}, 4, 0);
        cyc(PAT[6], 4'b0001, 1'b0);
        cyc(PAT[6], 4'b0001, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(v0), 32'd0);
        chk("t5_bcd", 32'(b0), 32'hFFFF);
        chk("t5_blank", 32'(bl0), 32'hF);
        chk("t5_err", 32'(er0), 32'd0);
        chk("t5_drop", 32'(d0), 32'd0);
        cyc(PAT[6], 4'b0001, 1'b1);
        rst_n = 1'b1;
        vb = vcnt;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) cyc(PAT[i], ND'(1) << i, 1'b1);
        chk("t5_partial", 32'(vcnt - vb), 32'd0);
        for (int k = 0; k < 4; k++) cyc(PAT[3], 4'b1000, 1'b1);
        chk("t5_full", 32'(vcnt - vb), 32'd1);

        // 6: active-low instance sees inverted nines
        scan({PAT[9], PAT[9], PAT[9], PAT[9]}, 4, 1);
        chk("t6_bcd", 32'(last1), 32'h9999);

        // random traffic
        for (int n = 0; n < 200; n++) begin
            logic [6:0]    p;
            logic [ND-1:0] sel;
            int            dw, c;
            c = $urandom_range(0, 9);
            sel = (c == 0) ? ND'($urandom) : ND'(1) << $urandom_range(0, ND-1);
            c = $urandom_range(0, 9);
            p = (c < 7) ? PAT[$urandom_range(0, 9)] : (c == 7) ? 7'd0 : 7'($urandom);
            dw = $urandom_range(1, 5);
            for (int k = 0; k < dw; k++) cyc(p, sel, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
